// File: rtl/clk_div_buffer.sv
// Multi-channel glitch-free clock divider with per-channel divisor, enable and tick strobe.
// Optional macro CLKDIV_ODD_DUTY_EN adds a negedge retime flop giving 50% duty on odd divisors.
module clk_div_buffer #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 8
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       active
);

  typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

  localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  function automatic logic [DIV_W-1:0] sat_div(input logic [DIV_W-1:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t           state_p0, state_nx;
    logic [DIV_W-1:0] cnt_p0, cnt_nx;
    logic [DIV_W-1:0] dl_p0, dl_nx;
    logic             clk_pos_p0, clk_pos_nx;
    logic             tick_p0, tick_nx;
    logic             act_p0, act_nx;
    logic             at_end;

    assign at_end = (cnt_p0 == (dl_p0 - DIV_ONE));

    always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
        state_p0   <= IDLE;
        cnt_p0     <= '0;
        dl_p0      <= DIV_MIN;
        clk_pos_p0 <= 1'b0;
        tick_p0    <= 1'b0;
        act_p0     <= 1'b0;
      end else begin
        state_p0   <= state_nx;
        cnt_p0     <= cnt_nx;
        dl_p0      <= dl_nx;
        clk_pos_p0 <= clk_pos_nx;
        tick_p0    <= tick_nx;
        act_p0     <= act_nx;
      end
    end

    // Outputs are computed from next-state so each is a single flop, one cycle start latency.
    always_comb begin
      state_nx = state_p0;
      cnt_nx   = cnt_p0;
      dl_nx    = dl_p0;
      unique case (state_p0)
        IDLE: begin
          cnt_nx = '0;
          if (en[i]) begin
            state_nx = RUN;
            dl_nx    = sat_div(div_val[i*DIV_W +: DIV_W]);
          end
        end
        RUN, STOP: begin
          if (at_end) begin
            cnt_nx   = '0;
            dl_nx    = sat_div(div_val[i*DIV_W +: DIV_W]);
            state_nx = en[i] ? RUN : IDLE;
          end else begin
            cnt_nx   = cnt_p0 + DIV_ONE;
            state_nx = en[i] ? RUN : STOP;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
      act_nx     = (state_nx != IDLE);
      clk_pos_nx = act_nx && (cnt_nx < (dl_nx >> 1));
      tick_nx    = act_nx && (cnt_nx == '0);
    end

`ifdef CLKDIV_ODD_DUTY_EN
    // Half-cycle extension of the high phase, only for odd divisors.
    logic clk_neg_p0;
    always_ff @(negedge clk_in or negedge rst_n) begin
      if (!rst_n) clk_neg_p0 <= 1'b0;
      else        clk_neg_p0 <= clk_pos_p0 & dl_p0[0];
    end
    assign clk_out[i] = clk_pos_p0 | clk_neg_p0;
`else
    assign clk_out[i] = clk_pos_p0;
`endif
    assign tick[i]   = tick_p0;
    assign active[i] = act_p0;
  end

endmodule

// File: tb/tb_clk_div_buffer.sv
// Directed bench for clk_div_buffer: reset, start/period, clamp, stop/restart, divisor change, odd D.
module tb_clk_div_buffer;
  localparam int NUM_CH = 4;
  localparam int DIV_W  = 8;

  logic                    clk_in = 1'b0;
  logic                    rst_n  = 1'b0;
  logic [NUM_CH-1:0]       en     = '0;
  logic [NUM_CH*DIV_W-1:0] div_val = '0;
  logic [NUM_CH-1:0]       clk_out, tick, active;

  int n_vec = 0;
  int n_err = 0;

  clk_div_buffer #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) dut (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (en),
    .div_val(div_val),
    .clk_out(clk_out),
    .tick   (tick),
    .active (active)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_div(input int ch, input int d);
    div_val[ch*DIV_W +: DIV_W] = DIV_W'(d);
  endtask

  // clk_out seen just after the rising edge; with the odd-duty macro the
  // negedge copy still holds the high level one cycle past the posedge phase.
  function automatic logic exp_clk(input int c, input int d);
`ifdef CLKDIV_ODD_DUTY_EN
    return (c < d / 2) || ((d % 2 == 1) && (c == d / 2));
`else
    return c < d / 2;
`endif
  endfunction

  initial begin
    // Reset state
    step();
    step();
    chk("rst_clk", 32'(clk_out), 32'h0);
    chk("rst_tick", 32'(tick), 32'h0);
    chk("rst_active", 32'(active), 32'h0);
    #2 rst_n = 1'b1;
    step();
    chk("rel_clk", 32'(clk_out), 32'h0);
    chk("rel_active", 32'(active), 32'h0);

    // Reset mid-run, D=6, during high phase
    set_div(0, 6);
    en[0] = 1'b1;
    step();
    chk("mr_start_clk", 32'(clk_out[0]), 32'h1);
    chk("mr_start_tick", 32'(tick[0]), 32'h1);
    chk("mr_start_act", 32'(active[0]), 32'h1);
    step();
    chk("mr_high", 32'(clk_out[0]), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("mr_async_clk", 32'(clk_out[0]), 32'h0);
    chk("mr_async_act", 32'(active[0]), 32'h0);
    en[0] = 1'b0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mr_post_clk", 32'(clk_out), 32'h0);
      chk("mr_post_tick", 32'(tick), 32'h0);
    end

    // Start and period, ch0 D=4
    set_div(0, 4);
    en[0] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("d4_clk", 32'(clk_out[0]), 32'((i % 4) < 2));
      chk("d4_tick", 32'(tick[0]), 32'((i % 4) == 0));
    end
    en[0] = 1'b0;
    step();
    chk("d4_stop_act", 32'(active[0]), 32'h0);
    chk("d4_stop_clk", 32'(clk_out[0]), 32'h0);

    // Clamp: ch1 D=0 then D=1 -> clk_in/2
    set_div(1, 0);
    en[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 6) set_div(1, 1);
      step();
      chk("clamp_clk", 32'(clk_out[1]), 32'((i % 2) == 0));
      chk("clamp_tick", 32'(tick[1]), 32'((i % 2) == 0));
    end
    en[1] = 1'b0;
    step();
    chk("clamp_stop_act", 32'(active[1]), 32'h0);

    // Graceful stop, ch2 D=5, en dropped at cnt=1
    set_div(2, 5);
    en[2] = 1'b1;
    step();
    chk("gs_c0_clk", 32'(clk_out[2]), 32'(exp_clk(0, 5)));
    step();
    chk("gs_c1_clk", 32'(clk_out[2]), 32'(exp_clk(1, 5)));
    en[2] = 1'b0;
    for (int c = 2; c < 5; c++) begin
      step();
      chk("gs_tail_clk", 32'(clk_out[2]), 32'(exp_clk(c, 5)));
      chk("gs_tail_act", 32'(active[2]), 32'h1);
    end
    step();
    chk("gs_idle_act", 32'(active[2]), 32'h0);
    chk("gs_idle_clk", 32'(clk_out[2]), 32'h0);
    chk("gs_idle_tick", 32'(tick[2]), 32'h0);

    // Restart: en dropped at cnt=1, re-raised at cnt=3 -> no gap
    en[2] = 1'b1;
    step();
    chk("rs_c0_tick", 32'(tick[2]), 32'h1);
    step();
    en[2] = 1'b0;
    step();
    step();
    en[2] = 1'b1;
    step();
    chk("rs_c4_act", 32'(active[2]), 32'h1);
    chk("rs_c4_clk", 32'(clk_out[2]), 32'(exp_clk(4, 5)));
    step();
    chk("rs_next_tick", 32'(tick[2]), 32'h1);
    chk("rs_next_clk", 32'(clk_out[2]), 32'h1);
    step();
    chk("rs_next_c1", 32'(clk_out[2]), 32'(exp_clk(1, 5)));
    en[2] = 1'b0;
    for (int i = 0; i < 3; i++) step();
    step();
    chk("rs_idle_act", 32'(active[2]), 32'h0);

    // Divisor change mid-period, ch3 4 -> 8
    set_div(3, 4);
    en[3] = 1'b1;
    step();
    step();
    set_div(3, 8);
    step();
    chk("dc_c2_clk", 32'(clk_out[3]), 32'h0);
    step();
    chk("dc_c3_clk", 32'(clk_out[3]), 32'h0);
    chk("dc_c3_tick", 32'(tick[3]), 32'h0);
    for (int j = 0; j < 9; j++) begin
      step();
      chk("dc_d8_clk", 32'(clk_out[3]), 32'((j % 8) < 4));
      chk("dc_d8_tick", 32'(tick[3]), 32'((j % 8) == 0));
    end
    en[3] = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("dc_idle_act", 32'(active[3]), 32'h0);

    // Odd divisor D=3 on ch0
    set_div(0, 3);
    en[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("d3_clk", 32'(clk_out[0]), 32'(exp_clk(i % 3, 3)));
      chk("d3_tick", 32'(tick[0]), 32'((i % 3) == 0));
    end
    en[0] = 1'b0;
    step();
    chk("d3_idle_act", 32'(active[0]), 32'h0);
    chk("final_all_idle", 32'(active), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
